// File: rtl/idu_pkg.sv
// Shared decode constants for the instruction decode/issue unit:
// opcodes, instruction field positions, immediate sizes and helpers.
package idu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INS_WFI = 32'h1050_0073;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;

    localparam int IMM_I_W  = 12;
    localparam int IMM_S_W  = 12;
    localparam int IMM_B_W  = 13;
    localparam int IMM_J_W  = 21;
    localparam int IMM_U_SH = 12;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_e;

    function automatic fmt_e fmt_of(input logic [6:0] opc);
        fmt_e f;
        unique case (opc)
            OPC_OP_IMM, OPC_LOAD,
            OPC_JALR, OPC_SYSTEM: f = FMT_I;
            OPC_STORE:            f = FMT_S;
            OPC_BRANCH:           f = FMT_B;
            OPC_LUI, OPC_AUIPC:   f = FMT_U;
            OPC_JAL:              f = FMT_J;
            default:              f = FMT_R;
        endcase
        return f;
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] ins,
                                           input fmt_e f);
        logic [31:0] imm;
        unique case (f)
            FMT_I:   imm = {{(32-IMM_I_W){ins[31]}}, ins[31:20]};
            FMT_S:   imm = {{(32-IMM_S_W){ins[31]}}, ins[31:25],
                            ins[11:7]};
            FMT_B:   imm = {{(32-IMM_B_W){ins[31]}}, ins[31], ins[7],
                            ins[30:25], ins[11:8], 1'b0};
            FMT_U:   imm = {ins[31:12], {IMM_U_SH{1'b0}}};
            FMT_J:   imm = {{(32-IMM_J_W){ins[31]}}, ins[31],
                            ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/idu_ins_fifo.sv
// Instruction queue storage: DEPTH entries, extra-MSB wrap pointers.
// An empty queue presents an all-zero head word.
module idu_ins_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/idu_queue.sv
// Decode/issue unit: instruction queue, operand forwarding, load-use stall.
// Define IDU_STALL_CNT_EN to add the idu_stall_cnt stall-cycle counter.
module idu_queue
    import idu_pkg::*;
#(
    parameter int INS_W   = 64,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int NUM_FWD = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ifu_idu_vld,
    input  logic [INS_W-1:0]        ifu_idu_ins,
    output logic                    idu_ifu_rdy,
    input  logic                    alu_idu_flush_vld,
    input  logic                    alu_idu_rdy,
    input  logic [NUM_FWD-1:0]      fwd_vld,
    input  logic [NUM_FWD-1:0]      fwd_ld,
    input  logic [NUM_FWD*5-1:0]    fwd_addr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    output logic [4:0]              idu_rf_src1_addr,
    output logic [4:0]              idu_rf_src2_addr,
    input  logic [DATA_W-1:0]       rf_idu_src1_data,
    input  logic [DATA_W-1:0]       rf_idu_src2_data,
    output logic                    idu_alu_vld,
    output logic [INS_W-1:0]        idu_alu_ins,
    output logic [DATA_W-1:0]       idu_alu_src1,
    output logic [DATA_W-1:0]       idu_alu_src2,
    output logic [4:0]              idu_alu_wb_addr,
    output logic                    idu_ifu_wfi
`ifdef IDU_STALL_CNT_EN
    ,
    output logic [31:0]             idu_stall_cnt
`endif
);

    logic [INS_W-1:0]  head_ins;
    logic              fifo_empty;
    logic              fifo_full;
    logic              head_vld;
    logic              push;
    logic              pop;
    logic              stall;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    fmt_e              fmt;
    logic              use1;
    logic              use2;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] imm;
    logic              st1;
    logic              st2;
    logic              hit1;
    logic              hit2;

    assign head_vld    = ~fifo_empty;
    assign idu_ifu_rdy = ~fifo_full;
    assign push = ifu_idu_vld & idu_ifu_rdy & ~alu_idu_flush_vld;
    assign pop  = head_vld & ~stall & ~alu_idu_flush_vld &
                  (~idu_alu_vld | alu_idu_rdy);

    idu_ins_fifo #(
        .W     (INS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (alu_idu_flush_vld),
        .push  (push),
        .pop   (pop),
        .din   (ifu_idu_ins),
        .dout  (head_ins),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign fmt  = fmt_of(head_ins[OPC_MSB:OPC_LSB]);
    assign rs1  = head_ins[RS1_MSB:RS1_LSB];
    assign rs2  = head_ins[RS2_MSB:RS2_LSB];
    assign use1 = (fmt != FMT_U) && (fmt != FMT_J);
    assign use2 = (fmt == FMT_R) || (fmt == FMT_B);
    assign imm  = DATA_W'($signed(imm_of(head_ins[31:0], fmt)));

    assign idu_rf_src1_addr = rs1;
    assign idu_rf_src2_addr = rs2;

    // Youngest matching writer wins; a load ahead of any ready match stalls.
    always_comb begin
        op1  = rf_idu_src1_data;
        op2  = rf_idu_src2_data;
        st1  = 1'b0;
        st2  = 1'b0;
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < NUM_FWD; i++) begin
            if (!hit1 && rs1 != 5'd0 && fwd_vld[i] &&
                fwd_addr[i*5 +: 5] == rs1) begin
                if (fwd_ld[i]) begin
                    st1 = 1'b1;
                end else begin
                    op1  = fwd_data[i*DATA_W +: DATA_W];
                    hit1 = 1'b1;
                end
            end
            if (!hit2 && rs2 != 5'd0 && fwd_vld[i] &&
                fwd_addr[i*5 +: 5] == rs2) begin
                if (fwd_ld[i]) begin
                    st2 = 1'b1;
                end else begin
                    op2  = fwd_data[i*DATA_W +: DATA_W];
                    hit2 = 1'b1;
                end
            end
        end
    end

    assign stall = head_vld & ((st1 & use1) | (st2 & use2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idu_alu_vld     <= 1'b0;
            idu_alu_ins     <= '0;
            idu_alu_src1    <= '0;
            idu_alu_src2    <= '0;
            idu_alu_wb_addr <= '0;
        end else if (alu_idu_flush_vld) begin
            idu_alu_vld <= 1'b0;
        end else if (pop) begin
            idu_alu_vld     <= 1'b1;
            idu_alu_ins     <= head_ins;
            idu_alu_src1    <= use1 ? op1 : '0;
            idu_alu_src2    <= use2 ? op2 : imm;
            idu_alu_wb_addr <= head_ins[RD_MSB:RD_LSB];
        end else if (alu_idu_rdy) begin
            idu_alu_vld <= 1'b0;
        end
    end

    assign idu_ifu_wfi = idu_alu_vld && (idu_alu_ins[31:0] == INS_WFI);

`ifdef IDU_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idu_stall_cnt <= '0;
        end else if (alu_idu_flush_vld) begin
            idu_stall_cnt <= '0;
        end else if (stall && idu_stall_cnt != 32'hFFFF_FFFF) begin
            idu_stall_cnt <= idu_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/idu_queue.md
IDU_QUEUE -- requirements
Module: idu_queue

Interface
REQ-001 SHALL have parameter INS_W, default 64, meaning instruction word width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning operand width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning instruction queue entries (power of 2, >=2).
REQ-004 SHALL have parameter NUM_FWD, default 3, meaning forwarding ports; index 0 is youngest.
REQ-005 SHALL have ports: clk input 1 clock; rst_n input 1 reset. One clock; reset is asynchronous and active-low.
REQ-006 SHALL have ports: ifu_idu_vld input 1 instruction valid; ifu_idu_ins input INS_W instruction; idu_ifu_rdy output 1 queue can accept.
REQ-007 SHALL have ports: alu_idu_flush_vld input 1 pipeline flush; alu_idu_rdy input 1 ALU accepts issue.
REQ-008 SHALL have ports: fwd_vld input NUM_FWD writer valid; fwd_ld input NUM_FWD writer is load (data not ready); fwd_addr input NUM_FWD*5 rd; fwd_data input NUM_FWD*DATA_W result.
REQ-009 SHALL have ports: idu_rf_src1_addr, idu_rf_src2_addr output 5 head rs1/rs2; rf_idu_src1_data, rf_idu_src2_data input DATA_W.
REQ-010 SHALL have ports: idu_alu_vld output 1; idu_alu_ins output INS_W; idu_alu_src1, idu_alu_src2 output DATA_W; idu_alu_wb_addr output 5; idu_ifu_wfi output 1.

Function
REQ-011 Queue SHALL push when ifu_idu_vld & idu_ifu_rdy & ~alu_idu_flush_vld; idu_ifu_rdy = (count < DEPTH), no same-cycle pop bypass when full.
REQ-012 Pointers SHALL be log2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full/empty from MSB compare.
REQ-013 RF addresses SHALL come combinationally from queue head; head-empty drives zeros.
REQ-014 Issue SHALL occur when head valid & ~stall & (~idu_alu_vld | alu_idu_rdy); output register loads ins, operands, rd; head pops same edge.
REQ-015 Minimum latency: instruction accepted on edge E0 SHALL present idu_alu_vld after edge E1.
REQ-016 idu_alu_vld SHALL hold with stable payload while alu_idu_rdy low; clears after accepted edge with no new issue.
REQ-017 Operand select per source: lowest-index port with fwd_vld & ~fwd_ld & addr match wins; else RF data.
REQ-018 Address 0 SHALL never match forwarding or stall; operand x0 = RF data.
REQ-019 stall SHALL assert when any port has fwd_vld & fwd_ld & addr match on a used source, and no lower-index non-load port matches.
REQ-020 src2 SHALL be immediate for I/S/U/J types (sign-extended per RISC-V); U/J use no rs1; I uses no rs2.
REQ-021 Flush SHALL empty queue, clear idu_alu_vld, and drop same-cycle push and issue.
REQ-022 idu_ifu_wfi SHALL equal idu_alu_vld & output opcode == WFI.

Reset
REQ-023 On rst_n low: pointers 0, idu_alu_vld 0, idu_ifu_wfi 0, idu_ifu_rdy 1 after release; payload registers reset to 0.
REQ-024 Reset mid-transfer SHALL discard all queued and issued instructions.

Configuration
REQ-025 With IDU_STALL_CNT_EN defined, output idu_stall_cnt [31:0] SHALL count cycles with head valid and stall high, saturating at 0xFFFFFFFF, reset 0, cleared by flush.
REQ-026 Without IDU_STALL_CNT_EN, port and counter SHALL be absent.

Structure
REQ-027 Opcode constants, field range macros, immediate sizes SHALL live in shared package idu_pkg.
REQ-028 Queue storage and pointers SHALL be sub-module idu_ins_fifo; decode, forward, issue stay top level.

Verification
REQ-029 Fill: DEPTH=4, 5 pushes with alu_idu_rdy=0 -> idu_ifu_rdy low after 4th; 5th held; order preserved on drain.
REQ-030 Forward priority: head ADD rs1=x5; port0 and port2 both rd=x5, data 0x11/0x22 -> idu_alu_src1=0x11.
REQ-031 Load-use: head rs2=x7, port1 fwd_ld=1 rd=x7 for 3 cycles -> no issue 3 cycles, then issue with port data; stall_cnt=3 when enabled.
REQ-032 x0: head rs1=x0, port0 rd=x0 data 0xDEAD -> src1 = RF data (0).
REQ-033 Flush with 3 queued and vld held -> next cycle idu_alu_vld=0, queue empty, rdy=1.
REQ-034 Immediate: ADDI imm=0xFFF -> idu_alu_src2=0xFFFFFFFF; WFI issue -> idu_ifu_wfi=1 until accepted.
